chirp_sweep_controller: RTL and testbench

CHIRP_SWEEP_CONTROLLER -- requirements
Module: chirp_sweep_controller

---
 rtl/chirp_sweep_controller.sv | 192 +++++++++++++++++++
 tb/tb_chirp_sweep_controller.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chirp_sweep_controller.sv
// Chirp sweep controller: steps a frequency tuning word (FTW) from a start
// value towards a stop value (up, down or triangle). Each value is held for a
// programmable number of clock cycles. Optional auto-repeat, abort and
// configuration checking are included.
module chirp_sweep_controller #(
    parameter int FTW_W   = 16,
    parameter int DWELL_W = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         mode,
    input  logic               repeat_en,
    input  logic [FTW_W-1:0]   ftw_start,
    input  logic [FTW_W-1:0]   ftw_stop,
    input  logic [FTW_W-1:0]   ftw_step,
    input  logic [DWELL_W-1:0] dwell_ticks,
    output logic [FTW_W-1:0]   ftw,
    output logic               busy,
    output logic               step_strobe,
    output logic               done,
    output logic               cfg_error
);

    typedef enum logic [1:0] {IDLE, DWELL, FINISH} state_t;

    localparam logic [1:0]         MODE_UP   = 2'b00;
    localparam logic [1:0]         MODE_DOWN = 2'b01;
    localparam logic [1:0]         MODE_TRI  = 2'b10;
    localparam logic [DWELL_W-1:0] DWELL_ONE = 1;

    state_t             state_reg;
    logic [FTW_W-1:0]   ftw_reg;
    logic               busy_reg;
    logic               step_strobe_reg;
    logic               done_reg;
    logic               cfg_error_reg;

    // Latched sweep configuration
    logic [1:0]         mode_reg;
    logic               repeat_reg;
    logic [FTW_W-1:0]   start_reg;
    logic [FTW_W-1:0]   stop_reg;
    logic [FTW_W-1:0]   step_reg;
    logic [DWELL_W-1:0] dwell_reload_reg;   // dwell length minus one
    logic [DWELL_W-1:0] dwell_cnt_reg;      // cycles left at current value
    logic               falling_reg;        // triangle is on its falling leg

    logic               cfg_valid;
    logic [FTW_W:0]     sum_ext;
    logic [FTW_W:0]     diff_ext;
    logic [FTW_W-1:0]   up_next;
    logic [FTW_W-1:0]   down_floor;
    logic [FTW_W-1:0]   down_next;
    logic               at_terminal;
    logic               tri_turn;
    logic [FTW_W-1:0]   ftw_next;

    // Validate the configuration presented on the inputs at start time
    always_comb begin
        cfg_valid = 1'b1;
        if (ftw_step == '0)
            cfg_valid = 1'b0;
        if (mode == 2'b11)
            cfg_valid = 1'b0;
        if ((mode == MODE_UP || mode == MODE_TRI) && (ftw_start > ftw_stop))
            cfg_valid = 1'b0;
        if ((mode == MODE_DOWN) && (ftw_start < ftw_stop))
            cfg_valid = 1'b0;
    end

    // Next FTW computed one bit wider so over/underflow clamps instead of wrapping
    always_comb begin
        sum_ext    = {1'b0, ftw_reg} + {1'b0, step_reg};
        diff_ext   = {1'b0, ftw_reg} - {1'b0, step_reg};
        up_next    = (sum_ext > {1'b0, stop_reg}) ? stop_reg : sum_ext[FTW_W-1:0];
        down_floor = (mode_reg == MODE_DOWN) ? stop_reg : start_reg;
        down_next  = (diff_ext[FTW_W] || (diff_ext[FTW_W-1:0] < down_floor))
                     ? down_floor : diff_ext[FTW_W-1:0];

        // Triangle turns around once the stop value has had its single dwell
        tri_turn    = (mode_reg == MODE_TRI) && !falling_reg && (ftw_reg == stop_reg);
        at_terminal = 1'b0;
        ftw_next    = up_next;
        case (mode_reg)
            MODE_UP: begin
                at_terminal = (ftw_reg == stop_reg);
                ftw_next    = up_next;
            end
            MODE_DOWN: begin
                at_terminal = (ftw_reg == stop_reg);
                ftw_next    = down_next;
            end
            default: begin
                if (falling_reg) begin
                    at_terminal = (ftw_reg == start_reg);
                    ftw_next    = down_next;
                end else begin
                    // Degenerate triangle (start == stop) ends after one dwell
                    at_terminal = (ftw_reg == stop_reg) && (ftw_reg == start_reg);
                    ftw_next    = tri_turn ? down_next : up_next;
                end
            end
        endcase
    end

    // Sweep state machine with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            ftw_reg          <= '0;
            busy_reg         <= 1'b0;
            step_strobe_reg  <= 1'b0;
            done_reg         <= 1'b0;
            cfg_error_reg    <= 1'b0;
            mode_reg         <= '0;
            repeat_reg       <= 1'b0;
            start_reg        <= '0;
            stop_reg         <= '0;
            step_reg         <= '0;
            dwell_reload_reg <= '0;
            dwell_cnt_reg    <= '0;
            falling_reg      <= 1'b0;
        end else begin
            step_strobe_reg <= 1'b0;
            done_reg        <= 1'b0;
            cfg_error_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start && !abort) begin
                        if (cfg_valid) begin
                            mode_reg         <= mode;
                            repeat_reg       <= repeat_en;
                            start_reg        <= ftw_start;
                            stop_reg         <= ftw_stop;
                            step_reg         <= ftw_step;
                            dwell_reload_reg <= (dwell_ticks == '0) ? '0 : dwell_ticks - DWELL_ONE;
                            dwell_cnt_reg    <= (dwell_ticks == '0) ? '0 : dwell_ticks - DWELL_ONE;
                            ftw_reg          <= ftw_start;
                            falling_reg      <= 1'b0;
                            busy_reg         <= 1'b1;
                            state_reg        <= DWELL;
                        end else begin
                            cfg_error_reg <= 1'b1;
                        end
                    end
                end
                DWELL: begin
                    if (abort) begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else if (dwell_cnt_reg != '0) begin
                        dwell_cnt_reg <= dwell_cnt_reg - DWELL_ONE;
                    end else begin
                        dwell_cnt_reg <= dwell_reload_reg;
                        if (at_terminal) begin
                            if (repeat_reg) begin
                                ftw_reg         <= start_reg;
                                falling_reg     <= 1'b0;
                                step_strobe_reg <= 1'b1;
                            end else begin
                                busy_reg  <= 1'b0;
                                done_reg  <= 1'b1;
                                state_reg <= FINISH;
                            end
                        end else begin
                            ftw_reg         <= ftw_next;
                            step_strobe_reg <= 1'b1;
                            if (tri_turn)
                                falling_reg <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign ftw         = ftw_reg;
    assign busy        = busy_reg;
    assign step_strobe = step_strobe_reg;
    assign done        = done_reg;
    assign cfg_error   = cfg_error_reg;

endmodule

// File: tb/tb_chirp_sweep_controller.sv
// Self-checking bench for chirp_sweep_controller: a table of directed sweeps
// with hand-derived FTW sequences, a few hand-written corner sequences, and
// randomized sweeps checked against a list-based reference model.
module tb_chirp_sweep_controller;

    localparam int FTW_W   = 16;
    localparam int DWELL_W = 24;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               abort;
    logic [1:0]         mode;
    logic               repeat_en;
    logic [FTW_W-1:0]   ftw_start;
    logic [FTW_W-1:0]   ftw_stop;
    logic [FTW_W-1:0]   ftw_step;
    logic [DWELL_W-1:0] dwell_ticks;
    logic [FTW_W-1:0]   ftw;
    logic               busy;
    logic               step_strobe;
    logic               done;
    logic               cfg_error;

    chirp_sweep_controller #(.FTW_W(FTW_W), .DWELL_W(DWELL_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .mode        (mode),
        .repeat_en   (repeat_en),
        .ftw_start   (ftw_start),
        .ftw_stop    (ftw_stop),
        .ftw_step    (ftw_step),
        .dwell_ticks (dwell_ticks),
        .ftw         (ftw),
        .busy        (busy),
        .step_strobe (step_strobe),
        .done        (done),
        .cfg_error   (cfg_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]        mode;
        logic              rep;
        logic [15:0]       fs;
        logic [15:0]       fp;
        logic [15:0]       st;
        logic [23:0]       dw;
        int                abort_at;
        bit                err;
        int                n;
        logic [7:0][15:0]  v;
    } vec_t;

    typedef struct packed {
        logic [15:0] ftw;
        logic        busy;
        logic        strobe;
        logic        done;
    } exp_t;

    vec_t        tbl[$];
    exp_t        tr[$];
    logic [15:0] vals_q[$];
    logic [15:0] last_ftw;
    int          n_vec = 0;
    int          n_err = 0;
    int          sweep_id = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] eftw, input logic ebusy,
                         input logic estr, input logic edone, input logic eerr);
        n_vec++;
        if (ftw !== eftw || busy !== ebusy || step_strobe !== estr ||
            done !== edone || cfg_error !== eerr) begin
            n_err++;
            $display("FAIL %s (sweep %0d): got ftw=%h busy=%b strobe=%b done=%b cfg_error=%b, want ftw=%h busy=%b strobe=%b done=%b cfg_error=%b",
                     name, sweep_id, ftw, busy, step_strobe, done, cfg_error,
                     eftw, ebusy, estr, edone, eerr);
        end
    endtask

    task automatic add_vec(input logic [1:0] m, input logic rep, input logic [15:0] fs,
                           input logic [15:0] fp, input logic [15:0] st, input logic [23:0] dw,
                           input int abort_at, input bit err, input int n,
                           input logic [15:0] v0, input logic [15:0] v1, input logic [15:0] v2,
                           input logic [15:0] v3, input logic [15:0] v4);
        vec_t e;
        e.mode = m; e.rep = rep; e.fs = fs; e.fp = fp; e.st = st; e.dw = dw;
        e.abort_at = abort_at; e.err = err; e.n = n;
        e.v = '0;
        e.v[0] = v0; e.v[1] = v1; e.v[2] = v2; e.v[3] = v3; e.v[4] = v4;
        tbl.push_back(e);
    endtask

    // Reference: the list of distinct FTW values visited in one sweep pass
    task automatic model_values(input logic [1:0] m, input int s, input int p, input int st);
        int v;
        vals_q.delete();
        v = s;
        vals_q.push_back(16'(v));
        if (m == 2'd0) begin
            while (v != p) begin v = (v + st > p) ? p : v + st; vals_q.push_back(16'(v)); end
        end else if (m == 2'd1) begin
            while (v != p) begin v = (v - st < p) ? p : v - st; vals_q.push_back(16'(v)); end
        end else begin
            while (v != p) begin v = (v + st > p) ? p : v + st; vals_q.push_back(16'(v)); end
            while (v != s) begin v = (v - st < s) ? s : v - st; vals_q.push_back(16'(v)); end
        end
    endtask

    function automatic bit model_invalid(input logic [1:0] m, input int s, input int p, input int st);
        return (st == 0) || (m == 2'd3) || (m != 2'd1 && s > p) || (m == 2'd1 && s < p);
    endfunction

    // Expand the value list into the expected per-cycle output trace
    task automatic build_trace(input logic rep, input int d);
        int pass_len;
        int pass;
        tr.delete();
        pass_len = vals_q.size() * d;
        pass = 0;
        if (!rep) begin
            for (int i = 0; i < vals_q.size(); i++)
                for (int c = 0; c < d; c++)
                    tr.push_back('{vals_q[i], 1'b1, (c == 0 && i > 0), 1'b0});
            tr.push_back('{vals_q[vals_q.size()-1], 1'b0, 1'b0, 1'b1});
        end else begin
            while (tr.size() < 2 * pass_len + 3) begin
                for (int i = 0; i < vals_q.size(); i++)
                    for (int c = 0; c < d; c++)
                        tr.push_back('{vals_q[i], 1'b1, (c == 0 && !(pass == 0 && i == 0)), 1'b0});
                pass++;
            end
        end
    endtask

    // Start one sweep and compare every cycle against the expected trace
    task automatic run_sweep(input logic [1:0] m, input logic rep, input logic [15:0] fs,
                             input logic [15:0] fp, input logic [15:0] st, input logic [23:0] dw,
                             input int abort_at, input bit err);
        int  d;
        int  ab;
        bit  aborted;
        int  k;
        sweep_id++;
        mode = m; repeat_en = rep; ftw_start = fs; ftw_stop = fp; ftw_step = st; dwell_ticks = dw;
        start = 1'b1; abort = 1'b0;
        tick();
        start = 1'b0;
        // Scramble the inputs: the captured configuration must be used
        mode = 2'($urandom); repeat_en = 1'($urandom); ftw_start = 16'($urandom);
        ftw_stop = 16'($urandom); ftw_step = 16'($urandom); dwell_ticks = 24'($urandom);
        if (err) begin
            check("cfg_error pulse", last_ftw, 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
            check("cfg_error clear", last_ftw, 1'b0, 1'b0, 1'b0, 1'b0);
            $display("sweep %0d: mode=%0d start=%h stop=%h step=%h dwell=%0d rejected",
                     sweep_id, m, fs, fp, st, dw);
            return;
        end
        d = (dw == 0) ? 1 : int'(dw);
        build_trace(rep, d);
        ab = abort_at;
        if (rep && (ab < 0 || ab >= tr.size())) ab = tr.size() - 1;
        aborted = 1'b0;
        k = 0;
        while (k < tr.size() && !aborted) begin
            check("sweep cycle", tr[k].ftw, tr[k].busy, tr[k].strobe, tr[k].done, 1'b0);
            if (k == ab) begin
                abort = 1'b1;
                start = 1'($urandom);
                tick();
                abort = 1'b0;
                start = 1'b0;
                check("abort to idle", tr[k].ftw, 1'b0, 1'b0, 1'b0, 1'b0);
                last_ftw = tr[k].ftw;
                aborted = 1'b1;
            end else begin
                start = tr[k].busy ? 1'($urandom) : 1'b0;
                tick();
                start = 1'b0;
            end
            k++;
        end
        if (!aborted) begin
            last_ftw = vals_q[vals_q.size()-1];
            check("idle after finish", last_ftw, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        $display("sweep %0d: mode=%0d rep=%0d start=%h stop=%h step=%h dwell=%0d cycles=%0d aborted=%0d",
                 sweep_id, m, rep, fs, fp, st, dw, k, aborted);
    endtask

    task automatic run_table_entry(input int idx);
        vals_q.delete();
        for (int i = 0; i < tbl[idx].n; i++) vals_q.push_back(tbl[idx].v[i]);
        run_sweep(tbl[idx].mode, tbl[idx].rep, tbl[idx].fs, tbl[idx].fp, tbl[idx].st,
                  tbl[idx].dw, tbl[idx].abort_at, tbl[idx].err);
    endtask

    initial begin
        int s, p, st, span, r;
        logic [1:0] m;

        // Directed sweeps with hand-derived value sequences
        add_vec(2'd0, 1'b0, 16'h012C, 16'h0140, 16'h0007, 24'd4, -1, 1'b0, 4, 16'h012C, 16'h0133, 16'h013A, 16'h0140, 16'h0);
        add_vec(2'd2, 1'b1, 16'h0100, 16'h0110, 16'h0008, 24'd2, -1, 1'b0, 5, 16'h0100, 16'h0108, 16'h0110, 16'h0108, 16'h0100);
        add_vec(2'd1, 1'b0, 16'h0010, 16'h0000, 16'hFFFF, 24'd1, -1, 1'b0, 2, 16'h0010, 16'h0000, 16'h0, 16'h0, 16'h0);
        add_vec(2'd0, 1'b0, 16'h0010, 16'h0020, 16'h0000, 24'd1, -1, 1'b1, 0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        add_vec(2'd3, 1'b0, 16'h0010, 16'h0020, 16'h0001, 24'd1, -1, 1'b1, 0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        add_vec(2'd0, 1'b0, 16'h0030, 16'h0020, 16'h0001, 24'd1, -1, 1'b1, 0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        add_vec(2'd1, 1'b0, 16'h0020, 16'h0030, 16'h0001, 24'd1, -1, 1'b1, 0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        add_vec(2'd0, 1'b0, 16'h0010, 16'h0020, 16'h0010, 24'd0, -1, 1'b0, 2, 16'h0010, 16'h0020, 16'h0, 16'h0, 16'h0);
        add_vec(2'd2, 1'b0, 16'h0055, 16'h0055, 16'h0003, 24'd2, -1, 1'b0, 1, 16'h0055, 16'h0, 16'h0, 16'h0, 16'h0);
        add_vec(2'd0, 1'b0, 16'h0000, 16'h0030, 16'h0010, 24'd3, 5, 1'b0, 4, 16'h0000, 16'h0010, 16'h0020, 16'h0030, 16'h0);
        add_vec(2'd0, 1'b0, 16'h0000, 16'h0008, 16'h0008, 24'd1, 2, 1'b0, 2, 16'h0000, 16'h0008, 16'h0, 16'h0, 16'h0);
        add_vec(2'd0, 1'b0, 16'h0000, 16'h000A, 16'h0004, 24'd1, -1, 1'b0, 4, 16'h0000, 16'h0004, 16'h0008, 16'h000A, 16'h0);
        add_vec(2'd0, 1'b0, 16'h0077, 16'h0077, 16'h0001, 24'd3, -1, 1'b0, 1, 16'h0077, 16'h0, 16'h0, 16'h0, 16'h0);

        reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0; repeat_en = 1'b0;
        ftw_start = '0; ftw_stop = '0; ftw_step = '0; dwell_ticks = '0;
        tick();
        tick();
        check("reset state", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        last_ftw = 16'h0000;
        tick();
        check("idle after reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < tbl.size(); i++) run_table_entry(i);

        // abort together with start in IDLE: abort wins, nothing happens
        sweep_id++;
        mode = 2'd0; repeat_en = 1'b0; ftw_start = 16'h0001; ftw_stop = 16'h0010;
        ftw_step = 16'h0001; dwell_ticks = 24'd1;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("abort beats start", last_ftw, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("abort beats start hold", last_ftw, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("sweep %0d: start with abort in idle", sweep_id);

        // reset mid-sweep together with start
        sweep_id++;
        mode = 2'd0; repeat_en = 1'b0; ftw_start = 16'h012C; ftw_stop = 16'h0140;
        ftw_step = 16'h0007; dwell_ticks = 24'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("mid-sweep before reset", 16'h0133, 1'b1, 1'b0, 1'b0, 1'b0);
        reset = 1'b1; start = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0;
        check("reset mid-sweep", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        check("no done after reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        last_ftw = 16'h0000;
        $display("sweep %0d: reset mid-sweep", sweep_id);
        run_table_entry(0);

        // Randomized sweeps against the reference model
        for (int it = 0; it < 30; it++) begin
            r = $urandom_range(0, 9);
            m = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            span = $urandom_range(0, 120);
            s = $urandom_range(0, 65535 - span);
            p = s + span;
            if (m == 2'd1) begin r = s; s = p; p = r; end
            if ($urandom_range(0, 9) == 0) begin r = s; s = p; p = r; end
            if ($urandom_range(0, 14) == 0) st = 0;
            else if ($urandom_range(0, 7) == 0) st = 65535;
            else st = $urandom_range(1, 40);
            if (!model_invalid(m, s, p, st)) model_values(m, s, p, st);
            run_sweep(m, 1'($urandom_range(0, 3) == 0), 16'(s), 16'(p), 16'(st),
                      24'($urandom_range(0, 3)),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1,
                      model_invalid(m, s, p, st));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
